decode_control_queue: RTL and testbench

Registered, buffered successor to the combinational control decoder; sits between fetch and execute.
- Decodes each accepted RV32I instruction word into control signals and register indices.
- Stores decoded entries in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Adds branch/jump decode, illegal-instruction flagging, load-use hazard bubbling, pipeline flush, and an illegal-instruction counter.

---
 rtl/decode_control_queue_if.sv | 41 ++++
 rtl/decode_control_queue.sv | 173 +++++++++++++++++
 tb/tb_decode_control_queue.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_control_queue_if.sv
// decode_control_queue_if: fetch-side handshake, execute-side handshake and decoded head fields.
interface decode_control_queue_if #(
    parameter int ILEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [ILEN-1:0]     in_instr;
    logic                out_valid;
    logic                out_ready;
    logic                flush;
    logic                ex_mem_read;
    logic [4:0]          ex_rd;
    logic                reg_write;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                branch;
    logic                jump;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0]          encoding;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                illegal;
    logic [CNT_W-1:0]    illegal_count;

    modport slave (
        input  in_valid, in_instr, out_ready, flush, ex_mem_read, ex_rd,
        output in_ready, out_valid, reg_write, alu_src, mem_read, mem_write, mem_to_reg,
               branch, jump, alu_op, encoding, rd, rs1, rs2, illegal, illegal_count
    );

    modport master (
        output in_valid, in_instr, out_ready, flush, ex_mem_read, ex_rd,
        input  in_ready, out_valid, reg_write, alu_src, mem_read, mem_write, mem_to_reg,
               branch, jump, alu_op, encoding, rd, rs1, rs2, illegal, illegal_count
    );
endinterface

// File: rtl/decode_control_queue.sv
// decode_control_queue: RV32I control decode into a DEPTH-entry FIFO with load-use bubbling and flush.
module decode_control_queue #(
    parameter int ILEN      = 32,
    parameter int DEPTH     = 2,
    parameter int ALU_OP_W  = 4,
    parameter int CNT_W     = 8,
    parameter int ENABLE_BJ = 1
) (
    input logic clk,
    input logic rst,
    decode_control_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic BJ = ENABLE_BJ != 0;
    localparam logic [2:0] ENC_R = 3'd0, ENC_I = 3'd1, ENC_S = 3'd2, ENC_B = 3'd3, ENC_U = 3'd4, ENC_J = 3'd5;

    typedef struct packed {
        logic                illegal;
        logic                uses_rs1;
        logic                uses_rs2;
        logic                reg_write;
        logic                alu_src;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                branch;
        logic                jump;
        logic [ALU_OP_W-1:0] alu_op;
        logic [2:0]          encoding;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    entry_t           dec, head;
    logic             ok, push, pop, hazard;
    logic [6:0]       opc, f7;
    logic [2:0]       f3;

    function automatic logic [3:0] alu_rr(input logic [2:0] f, input logic alt);
        case (f)
            3'b000:  alu_rr = alt ? 4'd1 : 4'd0;
            3'b001:  alu_rr = 4'd2;
            3'b010:  alu_rr = 4'd8;
            3'b011:  alu_rr = 4'd9;
            3'b100:  alu_rr = 4'd5;
            3'b101:  alu_rr = alt ? 4'd4 : 4'd3;
            3'b110:  alu_rr = 4'd6;
            default: alu_rr = 4'd7;
        endcase
    endfunction

    always_comb begin
        opc = bus.in_instr[6:0];
        f3  = bus.in_instr[14:12];
        f7  = bus.in_instr[31:25];
        dec = '0;
        ok  = 1'b0;
        case (opc)
            7'b0110011: begin
                ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                dec.encoding = ENC_R;
                {dec.uses_rs1, dec.uses_rs2, dec.reg_write} = 3'b111;
                dec.alu_op = ALU_OP_W'(alu_rr(f3, f7[5]));
            end
            7'b0010011: begin
                ok = f3 == 3'b001 ? f7 == 7'h00 : f3 != 3'b101 || f7 == 7'h00 || f7 == 7'h20;
                dec.encoding = ENC_I;
                {dec.uses_rs1, dec.alu_src, dec.reg_write} = 3'b111;
                dec.alu_op = ALU_OP_W'(alu_rr(f3, f3 == 3'b101 && f7[5]));
            end
            7'b0110111: begin
                ok = 1'b1;
                dec.encoding = ENC_U;
                dec.reg_write = 1'b1;
                dec.alu_op = ALU_OP_W'(4'd10);
            end
            7'b0000011: begin
                ok = f3 == 3'b010;
                dec.encoding = ENC_I;
                {dec.uses_rs1, dec.alu_src, dec.mem_read, dec.mem_to_reg, dec.reg_write} = 5'b11111;
            end
            7'b0100011: begin
                ok = f3 == 3'b010;
                dec.encoding = ENC_S;
                {dec.uses_rs1, dec.uses_rs2, dec.alu_src, dec.mem_write} = 4'b1111;
            end
            7'b1100011: begin
                ok = BJ && f3[2:1] != 2'b01;
                dec.encoding = ENC_B;
                {dec.uses_rs1, dec.uses_rs2, dec.branch} = 3'b111;
                dec.alu_op = ALU_OP_W'(f3[2] ? (f3[1] ? 4'd9 : 4'd8) : 4'd1);
            end
            7'b1101111: begin
                ok = BJ;
                dec.encoding = ENC_J;
                {dec.jump, dec.reg_write} = 2'b11;
            end
            7'b1100111: begin
                ok = BJ && f3 == 3'b000;
                dec.encoding = ENC_I;
                {dec.uses_rs1, dec.jump, dec.alu_src, dec.reg_write} = 4'b1111;
            end
            7'b0010111: begin
                ok = BJ;
                dec.encoding = ENC_U;
                dec.reg_write = 1'b1;
                dec.alu_op = ALU_OP_W'(4'd11);
            end
            default: ok = 1'b0;
        endcase
        // Illegal words still carry their raw register fields so trap logic can inspect them.
        if (!ok) begin
            dec = '0;
            dec.illegal = 1'b1;
        end
        dec.rd  = bus.in_instr[11:7];
        dec.rs1 = bus.in_instr[19:15];
        dec.rs2 = bus.in_instr[24:20];
    end

    always_comb begin
        head    = mem_q[rptr_q];
        hazard  = bus.ex_mem_read && bus.ex_rd != 5'd0 &&
                  ((head.uses_rs1 && head.rs1 == bus.ex_rd) || (head.uses_rs2 && head.rs2 == bus.ex_rd));
        push    = bus.in_valid && bus.in_ready && !bus.flush;
        pop     = bus.out_valid && bus.out_ready;
        mem_d   = mem_q;
        if (push) mem_d[wptr_q] = dec;
        wptr_d    = bus.flush ? '0 : wptr_q + AW'(push);
        rptr_d    = bus.flush ? '0 : rptr_q + AW'(pop);
        count_d   = bus.flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        ill_cnt_d = push && dec.illegal && ill_cnt_q != '1 ? ill_cnt_q + CNT_W'(1) : ill_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q     <= '{default: '0};
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ill_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign bus.in_ready      = count_q != (AW+1)'(DEPTH);
    assign bus.out_valid     = count_q != '0 && !hazard && !bus.flush;
    assign bus.reg_write     = head.reg_write;
    assign bus.alu_src       = head.alu_src;
    assign bus.mem_read      = head.mem_read;
    assign bus.mem_write     = head.mem_write;
    assign bus.mem_to_reg    = head.mem_to_reg;
    assign bus.branch        = head.branch;
    assign bus.jump          = head.jump;
    assign bus.alu_op        = head.alu_op;
    assign bus.encoding      = head.encoding;
    assign bus.rd            = head.rd;
    assign bus.rs1           = head.rs1;
    assign bus.rs2           = head.rs2;
    assign bus.illegal       = head.illegal;
    assign bus.illegal_count = ill_cnt_q;
endmodule

// File: tb/tb_decode_control_queue.sv
// tb_decode_control_queue: random and directed traffic scored against a queue-based RV32I decode model.
module tb_decode_control_queue;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic       illegal;
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic [3:0] alu_op;
        logic [2:0] encoding;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   exp_cnt = 0;
    bit   acc_ready = 1'b1;
    exp_t act1, act2;

    decode_control_queue_if bus ();
    decode_control_queue_if bus2 ();

    decode_control_queue #(.ENABLE_BJ(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    decode_control_queue #(.ENABLE_BJ(0)) dut_nobj (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    assign act1 = {bus.illegal, bus.reg_write, bus.alu_src, bus.mem_read, bus.mem_write, bus.mem_to_reg,
                   bus.branch, bus.jump, bus.alu_op, bus.encoding, bus.rd, bus.rs1, bus.rs2};
    assign act2 = {bus2.illegal, bus2.reg_write, bus2.alu_src, bus2.mem_read, bus2.mem_write, bus2.mem_to_reg,
                   bus2.branch, bus2.jump, bus2.alu_op, bus2.encoding, bus2.rd, bus2.rs1, bus2.rs2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s act=%h req=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w, input bit bj);
        exp_t       e;
        bit         legal;
        int         alu_by_f3 [8];
        logic [6:0] op, f7;
        logic [2:0] f3;
        alu_by_f3 = '{0, 2, 8, 9, 5, 3, 6, 7};
        op = w[6:0];
        f7 = w[31:25];
        f3 = w[14:12];
        e = '0;
        legal = 1'b0;
        if (op == 7'h33) begin
            legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.reg_write = 1'b1;
            e.alu_op = f7 == 7'h20 ? (f3 == 3'd0 ? 4'd1 : 4'd4) : 4'(alu_by_f3[f3]);
        end else if (op == 7'h13) begin
            legal = f3 == 3'd1 ? f7 == 7'h00 : (f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1);
            e.encoding = 3'd1;
            e.alu_src = 1'b1;
            e.reg_write = 1'b1;
            e.alu_op = (f3 == 3'd5 && f7 == 7'h20) ? 4'd4 : 4'(alu_by_f3[f3]);
        end else if (op == 7'h37) begin
            legal = 1'b1;
            e.encoding = 3'd4;
            e.reg_write = 1'b1;
            e.alu_op = 4'd10;
        end else if (op == 7'h03) begin
            legal = f3 == 3'd2;
            e.encoding = 3'd1;
            e.alu_src = 1'b1;
            e.mem_read = 1'b1;
            e.mem_to_reg = 1'b1;
            e.reg_write = 1'b1;
        end else if (op == 7'h23) begin
            legal = f3 == 3'd2;
            e.encoding = 3'd2;
            e.alu_src = 1'b1;
            e.mem_write = 1'b1;
        end else if (op == 7'h63) begin
            legal = bj && f3 != 3'd2 && f3 != 3'd3;
            e.encoding = 3'd3;
            e.branch = 1'b1;
            e.alu_op = f3 < 3'd4 ? 4'd1 : (f3 < 3'd6 ? 4'd8 : 4'd9);
        end else if (op == 7'h6F) begin
            legal = bj;
            e.encoding = 3'd5;
            e.jump = 1'b1;
            e.reg_write = 1'b1;
        end else if (op == 7'h67) begin
            legal = bj && f3 == 3'd0;
            e.encoding = 3'd1;
            e.jump = 1'b1;
            e.alu_src = 1'b1;
            e.reg_write = 1'b1;
        end else if (op == 7'h17) begin
            legal = bj;
            e.encoding = 3'd4;
            e.reg_write = 1'b1;
            e.alu_op = 4'd11;
        end
        if (!legal) begin
            e = '0;
            e.illegal = 1'b1;
        end
        e.rd = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        return e;
    endfunction

    // R/I/S/B formats carry rs1; R/S/B also carry rs2.
    function automatic bit haz(input exp_t e, input logic mr, input logic [4:0] xrd);
        bit has1, has2;
        has1 = !e.illegal && e.encoding <= 3'd3;
        has2 = !e.illegal && (e.encoding == 3'd0 || e.encoding == 3'd2 || e.encoding == 3'd3);
        return mr && xrd != 5'd0 && ((has1 && e.rs1 == xrd) || (has2 && e.rs2 == xrd));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9];
        int         k;
        logic [2:0] f3;
        logic [6:0] f7;
        ops = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h17};
        k = $urandom_range(0, 11);
        if (k == 10) return $urandom;
        if (k == 11) return 32'hFFFF_FFFF;
        f3 = 3'($urandom);
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        if ((k == 3 || k == 4 || k == 7) && $urandom_range(0, 1) == 1) f3 = (k == 7) ? 3'd0 : 3'd2;
        return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 31)), ops[k]};
    endfunction

    // Scoreboard push side: accepted words enter the expected queue at the edge.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_cnt = 0;
        end else if (bus.in_valid && acc_ready && !bus.flush) begin
            exp_t e;
            e = model(bus.in_instr, 1'b1);
            exp_q.push_back(e);
            if (e.illegal && exp_cnt != 255) exp_cnt++;
        end
    end

    // Monitor: compares handshake and head against the expected queue, pops on issue.
    initial forever begin
        bit ev, er;
        @(negedge clk);
        if (!rst) begin
            er = exp_q.size() < DEPTH;
            ev = 1'b0;
            if (exp_q.size() != 0) ev = !haz(exp_q[0], bus.ex_mem_read, bus.ex_rd) && !bus.flush;
            check("in_ready", 32'(bus.in_ready), 32'(er));
            check("out_valid", 32'(bus.out_valid), 32'(ev));
            check("illegal_count", 32'(bus.illegal_count), 32'(exp_cnt));
            if (ev && bus.out_ready) begin
                check("head", 32'(act1), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            if (bus.flush) exp_q.delete();
            acc_ready = er;
        end
    end

    task automatic step(input logic v, input logic [31:0] w, input logic ordy, input logic fl,
                        input logic mr, input logic [4:0] xrd);
        bus.in_valid = v;
        bus.in_instr = w;
        bus.out_ready = ordy;
        bus.flush = fl;
        bus.ex_mem_read = mr;
        bus.ex_rd = xrd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_head", 32'(act1), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.illegal_count), 32'd0);
        check("rst_head_nobj", 32'(act2), 32'h0);
        check("rst_count_nobj", 32'(bus2.illegal_count), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.out_ready = 1'b1;
        bus.flush = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rd = '0;
        bus2.in_valid = 1'b0;
        bus2.in_instr = '0;
        bus2.out_ready = 1'b0;
        bus2.flush = 1'b0;
        bus2.ex_mem_read = 1'b0;
        bus2.ex_rd = '0;
        do_reset();
        step(1'b1, 32'h0050_0093, 1'b1, 1'b0, 1'b0, 5'd0);
        idle();
        step(1'b1, 32'h4020_81B3, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 32'h4020_81B3, 1'b0, 1'b0, 1'b0, 5'd0);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        repeat (3) idle();
        step(1'b1, 32'h0002_8333, 1'b1, 1'b0, 1'b1, 5'd5);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd5);
        step(1'b1, 32'h0002_8333, 1'b1, 1'b0, 1'b1, 5'd0);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0);
        step(1'b1, 32'h0020_8463, 1'b1, 1'b0, 1'b0, 5'd0);
        idle();
        bus2.in_valid = 1'b1;
        bus2.in_instr = 32'h0020_8463;
        idle();
        bus2.in_instr = 32'h0080_00EF;
        idle();
        bus2.in_valid = 1'b0;
        @(negedge clk);
        check("nobj_valid", 32'(bus2.out_valid), 32'd1);
        check("nobj_illegal", 32'(bus2.illegal), 32'd1);
        check("nobj_branch", 32'(bus2.branch), 32'd0);
        check("nobj_count", 32'(bus2.illegal_count), 32'd2);
        @(posedge clk);
        #1;
        repeat (300) step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'd0);
        repeat (2) idle();
        step(1'b1, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 32'h0070_0113, 1'b0, 1'b1, 1'b0, 5'd0);
        repeat (2) idle();
        repeat (2) step(1'b1, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 32'h0070_0113, 1'b0, 1'b1, 1'b0, 5'd0);
        repeat (2) idle();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                repeat (2) step(1'b1, rand_instr(), 1'b0, 1'b0, 1'b0, 5'd0);
                do_reset();
            end
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
        end
        repeat (3) idle();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
